// File: rtl/alu_pkg.sv
// ALU opcode table, MIPS opcode/funct constants and the decode-result struct
// shared by the ID->EX decoder.
package alu_pkg;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_AND  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011;
  localparam logic [4:0] ALU_NOR  = 5'b00100;
  localparam logic [4:0] ALU_SLL  = 5'b00101;
  localparam logic [4:0] ALU_SRL  = 5'b00110;
  localparam logic [4:0] ALU_SRA  = 5'b00111;
  localparam logic [4:0] ALU_SLT  = 5'b01000;
  localparam logic [4:0] ALU_LUI  = 5'b01001;
  localparam logic [4:0] ALU_BNE  = 5'b01010;
  localparam logic [4:0] ALU_BGTZ = 5'b01011;
  localparam logic [4:0] ALU_BGEZ = 5'b01100;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [4:0] REGIMM_BGEZ = 5'd1;

  typedef enum logic [1:0] {
    IMM_RT   = 2'd0,
    IMM_SEXT = 2'd1,
    IMM_ZEXT = 2'd2
  } imm_sel_e;

  typedef struct packed {
    logic [4:0] alu_op;
    imm_sel_e   imm_sel;
    logic       dest_rd;    // 1: dest = rd (R-type), 0: dest = rt
    logic       reg_write;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational MIPS instruction classifier. Illegal-instruction flagging is
// only built when ID_EX_ILLEGAL_DETECT_EN is defined.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0] op, funct;
  logic [4:0] rt, rd;
  logic       unused_bits;

  assign op     = instr[31:26];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];
  assign unused_bits = ^{instr[25:21], instr[10:6]};

  always_comb begin
    dec           = '0;
    dec.alu_op    = ALU_ADD;
    dec.imm_sel   = IMM_RT;
    case (op)
      OP_RTYPE: begin
        dec.dest_rd   = 1'b1;
        dec.reg_write = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: dec.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: dec.alu_op = ALU_SUB;
          FN_AND:          dec.alu_op = ALU_AND;
          FN_OR:           dec.alu_op = ALU_OR;
          FN_NOR:          dec.alu_op = ALU_NOR;
          FN_SLL:          dec.alu_op = ALU_SLL;
          FN_SRL:          dec.alu_op = ALU_SRL;
          FN_SRA:          dec.alu_op = ALU_SRA;
          FN_SLT:          dec.alu_op = ALU_SLT;
          default: begin
            dec.reg_write = 1'b0;
`ifdef ID_EX_ILLEGAL_DETECT_EN
            dec.illegal   = 1'b1;
`endif
          end
        endcase
        // writes to $zero are architecturally discarded
        if (rd == 5'd0) dec.reg_write = 1'b0;
      end
      OP_ADDI, OP_ADDIU, OP_LW: begin
        dec.imm_sel   = IMM_SEXT;
        dec.reg_write = 1'b1;
      end
      OP_SW:   dec.imm_sel = IMM_SEXT;
      OP_SLTI: begin
        dec.alu_op    = ALU_SLT;
        dec.imm_sel   = IMM_SEXT;
        dec.reg_write = 1'b1;
      end
      OP_ANDI: begin
        dec.alu_op    = ALU_AND;
        dec.imm_sel   = IMM_ZEXT;
        dec.reg_write = 1'b1;
      end
      OP_ORI: begin
        dec.alu_op    = ALU_OR;
        dec.imm_sel   = IMM_ZEXT;
        dec.reg_write = 1'b1;
      end
      OP_LUI: begin
        dec.alu_op    = ALU_LUI;
        dec.imm_sel   = IMM_ZEXT;
        dec.reg_write = 1'b1;
      end
      OP_BEQ:  dec.alu_op = ALU_SUB;
      OP_BNE:  dec.alu_op = ALU_BNE;
      OP_BGTZ: dec.alu_op = ALU_BGTZ;
      OP_REGIMM: begin
        if (rt == REGIMM_BGEZ) dec.alu_op = ALU_BGEZ;
`ifdef ID_EX_ILLEGAL_DETECT_EN
        else                   dec.illegal = 1'b1;
`endif
      end
      default: begin
`ifdef ID_EX_ILLEGAL_DETECT_EN
        dec.illegal = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/id_ex_decode.sv
// One-stage registered ID->EX decoder with valid/ready handshake.
// Optional: ID_EX_ILLEGAL_DETECT_EN enables the registered ex_illegal flag.
module id_ex_decode
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_rs_data,
  input  logic [XLEN-1:0] id_rt_data,
  input  logic            ex_stall,
  input  logic            ex_flush,
  output logic            ex_valid,
  output logic [4:0]      ex_alu_op,
  output logic [XLEN-1:0] ex_arg1,
  output logic [XLEN-1:0] ex_arg2,
  output logic [4:0]      ex_shamt,
  output logic [4:0]      ex_dest,
  output logic            ex_reg_write,
  output logic            ex_illegal
);

  dec_t            dec;
  logic [XLEN-1:0] arg2_d;
  logic [4:0]      shamt_d, dest_d;
  logic [15:0]     imm;
  logic            load;
  logic            unused_rs;

  alu_op_decoder u_dec (.instr(id_instr), .dec(dec));

  assign imm       = id_instr[15:0];
  assign unused_rs = ^id_instr[25:21];
  assign id_ready  = !ex_valid || !ex_stall;
  assign load      = id_valid && id_ready;

  always_comb begin
    arg2_d = id_rt_data;
    case (dec.imm_sel)
      IMM_SEXT: arg2_d = {{(XLEN-16){imm[15]}}, imm};
      IMM_ZEXT: arg2_d = {{(XLEN-16){1'b0}}, imm};
      default:  arg2_d = id_rt_data;
    endcase
    dest_d  = dec.dest_rd ? id_instr[15:11] : id_instr[20:16];
    shamt_d = dec.dest_rd ? id_instr[10:6]  : 5'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_alu_op    <= ALU_ADD;
      ex_arg1      <= '0;
      ex_arg2      <= '0;
      ex_shamt     <= '0;
      ex_dest      <= '0;
      ex_reg_write <= 1'b0;
    end else if (ex_flush) begin
      ex_valid     <= 1'b0;
    end else if (load) begin
      ex_valid     <= 1'b1;
      ex_alu_op    <= dec.alu_op;
      ex_arg1      <= id_rs_data;
      ex_arg2      <= arg2_d;
      ex_shamt     <= shamt_d;
      ex_dest      <= dest_d;
      ex_reg_write <= dec.reg_write;
    end else if (id_ready) begin
      ex_valid     <= 1'b0;
    end
  end

`ifdef ID_EX_ILLEGAL_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   ex_illegal <= 1'b0;
    else if (!ex_flush && load)   ex_illegal <= dec.illegal;
  end
`else
  logic unused_ill;
  assign unused_ill = dec.illegal;
  assign ex_illegal = 1'b0;
`endif

endmodule

// File: doc/id_ex_decode.md
ID_EX_DECODE -- requirements
Module: id_ex_decode

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand width; only 32 is supported.
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  instruction offered.
- id_ready  out  1  instruction accepted this cycle when high with id_valid.
- id_instr  in  32  MIPS instruction word.
- id_rs_data  in  XLEN  register-file value of rs.
- id_rt_data  in  XLEN  register-file value of rt.
- ex_stall  in  1  execute stage cannot take a new op.
- ex_flush  in  1  discard the held op.
- ex_valid  out  1  registered op present.
- ex_alu_op  out  5  ALU opcode.
- ex_arg1  out  XLEN  ALU first operand (rs).
- ex_arg2  out  XLEN  ALU second operand.
- ex_shamt  out  5  shift amount.
- ex_dest  out  5  destination register.
- ex_reg_write  out  1  writeback enable.
- ex_illegal  out  1  unrecognised instruction.

Function
REQ-003 SHALL be a one-stage registered decoder; an accepted instruction appears on ex_* the next cycle, with latency 1.
REQ-004 id_ready SHALL equal (!ex_valid || !ex_stall); it is combinational and never depends on id_valid.
REQ-005 On each clock, one of four actions SHALL apply:
- Flush: if ex_flush, ex_valid SHALL go to 0. Flush has priority over load and stall, and the instruction offered that cycle is dropped.
- Load: else if id_valid && id_ready, all ex_* SHALL load the decoded values and ex_valid SHALL go to 1.
- Drain: else if id_ready, ex_valid SHALL go to 0 (bubble).
- Stall: else all ex_* SHALL hold.
REQ-006 R-type (opcode 0) SHALL decode by funct:
- 0x20 and 0x21 decode to add 00000; 0x22 and 0x23 to sub 00001.
- 0x24 decodes to and 00010; 0x25 to or 00011; 0x27 to nor 00100.
- 0x00 decodes to sll 00101; 0x02 to srl 00110; 0x03 to sra 00111; 0x2A to slt 01000.
- Outputs: arg2 = id_rt_data, dest = rd, reg_write = 1, shamt = instr[10:6].
REQ-007 I-type SHALL decode as follows (dest = rt, shamt = 0):
- addi/addiu 0x08/0x09, lw 0x23, sw 0x2B: add, with sign-extended imm.
- slti 0x0A: slt, with sign-extended imm.
- andi 0x0C and ori 0x0D: and and or, with zero-extended imm.
- lui 0x0F: 01001, with zero-extended imm.
REQ-008 Branches SHALL decode as follows, each with reg_write = 0 and arg2 = id_rt_data:
- beq 0x04: sub.
- bne 0x05: 01010.
- bgtz 0x07: 01011.
- opcode 0x01 with rt = 1: bgez 01100.
REQ-009 reg_write SHALL be 1 for the R-type ops, addi/addiu, lw, slti, andi, ori and lui, and 0 for sw and branches.
REQ-010 Any R-type with dest 0 SHALL force reg_write = 0.
REQ-011 An unlisted opcode or funct SHALL decode as add with reg_write = 0.

Reset
REQ-012 While rst_n is low, all ex_* SHALL be 0 (ex_alu_op = 00000), asynchronously; a reset asserted mid-stall discards the held op.
REQ-013 After rst_n deasserts, id_ready SHALL be 1 in the first cycle.

Configuration
REQ-014 With macro ID_EX_ILLEGAL_DETECT_EN defined, ex_illegal SHALL register 1 for instructions matching REQ-011, and 0 otherwise.
REQ-015 Without ID_EX_ILLEGAL_DETECT_EN, ex_illegal SHALL be constant 0 and no detection logic SHALL be present.

Structure
REQ-016 Package alu_pkg SHALL hold the 5-bit ALU opcode constants (matching the ALU table) and the MIPS opcode/funct constants.
REQ-017 Combinational sub-module alu_op_decoder SHALL map instr to {alu_op, imm-select, dest-select, reg_write, illegal}; id_ex_decode holds the registers and the handshake.

Verification
REQ-018 The bench SHALL cover:
- id_instr = 0x012A4020, rs = 5, rt = 7 -> next cycle alu_op = 00000, arg1 = 5, arg2 = 7, dest = 8, reg_write = 1.
- 0x2128FFFF -> alu_op = 00000, arg2 = 0xFFFFFFFF, dest = 8, reg_write = 1; 0x3C011234 -> alu_op = 01001, arg2 = 0x00001234, dest = 1.
- 0x00031103, rt = 0x80000000 -> alu_op = 00111, shamt = 4, arg2 = 0x80000000, dest = 2.
- ex_valid = 1, ex_stall = 1 for 3 cycles -> id_ready = 0 and ex_* unchanged. ex_flush and id_valid raised together -> ex_valid = 0 and the new instruction is dropped.
- 0xFC000000 -> ex_illegal = 1 and reg_write = 0 with ID_EX_ILLEGAL_DETECT_EN defined, ex_illegal = 0 without it. rst_n pulled low mid-stream -> all ex_* = 0 immediately.
